// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared types and constants for the codec configuration sequencer.
// Holds the FSM state enum, the default register table, the volume entry indices
// and volume limits, plus a helper that builds a table word for a given volume.
package codec_cfg_pkg;

  localparam int unsigned TBL_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned VOL_W     = 7;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_IDLE
  } cfg_state_e;

  localparam logic [IDX_W-1:0] VOL_L_IDX = 4'd6;
  localparam logic [IDX_W-1:0] VOL_R_IDX = 4'd7;

  localparam logic [VOL_W-1:0] VOL_MIN   = 7'h30;
  localparam logic [VOL_W-1:0] VOL_MAX   = 7'h7F;
  localparam logic [VOL_W-1:0] MUTE_CODE = 7'h2F;

  // Volume entries hold the register address only; the data field is filled at issue time.
  localparam logic [15:0] CFG_TABLE [TBL_DEPTH] = '{
    16'h0C00, 16'h0EC2, 16'h0838, 16'h1000,
    16'h0017, 16'h0217, 16'h0400, 16'h0600,
    16'h1201, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  // Table word for an index, with the volume field substituted on the headphone entries.
  function automatic logic [15:0] cfg_word(input logic [IDX_W-1:0] idx,
                                           input logic [VOL_W-1:0] vol_field);
    logic [15:0] w;
    w = CFG_TABLE[idx];
    if (idx == VOL_L_IDX || idx == VOL_R_IDX) begin
      w[7:0] = {1'b0, vol_field};
    end
    return w;
  endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// codec_cfg_seq_if: write handshake between the sequencer and the I2C write master.
//   tx_req   sequencer -> master  write request, held until tx_ack
//   tx_data  sequencer -> master  {dev_addr, reg_addr[6:0], reg_data[8:0]}
//   tx_ack   master -> sequencer  request accepted (one cycle)
//   tx_done  master -> sequencer  transfer finished (one cycle)
//   tx_nack  master -> sequencer  valid with tx_done: codec NACKed
// modport master: the sequencer side; modport slave: the I2C write master side.
interface codec_cfg_seq_if;
  logic        tx_req;
  logic [23:0] tx_data;
  logic        tx_ack;
  logic        tx_done;
  logic        tx_nack;

  modport master (output tx_req, output tx_data,
                  input  tx_ack, input  tx_done, input tx_nack);
  modport slave  (input  tx_req, input  tx_data,
                  output tx_ack, output tx_done, output tx_nack);
endinterface

// File: rtl/cfg_tick_gen.sv
// cfg_tick_gen: I2C bit-rate tick. Counter runs 0..CLK_DIV-1 and wraps; tick is
// high for the one cycle in which the counter holds CLK_DIV-1.
//   CLOCK  in   system clock
//   RESET  in   asynchronous active-high reset
//   tick   out  registered one-cycle pulse every CLK_DIV cycles
module cfg_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Wrapping divider count.
  always_comb begin
    cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Tick is registered alongside the count so it aligns with cnt_q == CNT_LAST.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tick  <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: audio-codec I2C configuration sequencer.
// After reset waits PWRUP_DLY cycles, streams NUM_REGS table entries to the I2C
// write master (re-issuing NACKed entries up to MAX_RETRY times), then services
// volume up/down requests by rewriting the left/right headphone registers.
//   CLOCK, RESET        clock, asynchronous active-high reset
//   I2C_TICK            bit-rate enable for the I2C master
//   bus (master)        tx_req/tx_data out, tx_ack/tx_done/tx_nack in
//   vol_up, vol_dn      single-cycle volume requests
//   mute                (SOFT_MUTE_EN only) soft mute level
//   volume              current volume setting
//   cfg_busy            a write sequence is in progress
//   cfg_done, cfg_err   sticky: init table finished / an entry ran out of retries
// Optional feature macro: SOFT_MUTE_EN (adds the mute input).
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int unsigned      CLK_DIV     = 250,
  parameter logic [7:0]       DEV_ADDR    = 8'h34,
  parameter int unsigned      NUM_REGS    = 9,
  parameter int unsigned      MAX_RETRY   = 3,
  parameter int unsigned      PWRUP_DLY   = 1024,
  parameter logic [VOL_W-1:0] VOL_DEFAULT = 7'h61
) (
  input  logic             CLOCK,
  input  logic             RESET,
  output logic             I2C_TICK,
  codec_cfg_seq_if.master  bus,
`ifdef SOFT_MUTE_EN
  input  logic             mute,
`endif
  input  logic             vol_up,
  input  logic             vol_dn,
  output logic [VOL_W-1:0] volume,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int unsigned PWR_W = (PWRUP_DLY > 0) ? $clog2(PWRUP_DLY + 1) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  localparam logic [PTR_W-1:0] NUM_REGS_P = PTR_W'(NUM_REGS);
  localparam logic [PTR_W-1:0] VOL_L_P    = {1'b0, VOL_L_IDX};
  localparam logic [PTR_W-1:0] VOL_R_P    = {1'b0, VOL_R_IDX};
  // A volume pass is only meaningful when both headphone entries are in the table.
  localparam bit VOL_PASS_OK = (NUM_REGS > 32'(VOL_R_IDX));

  cfg_state_e       state_q, state_nxt;
  logic [PTR_W-1:0] idx_q, idx_nxt, idx_inc;
  logic [RTY_W-1:0] retry_q, retry_nxt;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_nxt;
  logic             vol_pass_q, vol_pass_nxt;
  logic             vol_pend_q, pend_clr;
  logic [VOL_W-1:0] volume_q, vol_field;
  logic             tx_req_q, tx_req_nxt;
  logic [23:0]      tx_data_q, tx_data_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             retry_left;
  logic             up_ok, dn_ok, mute_chg;

  cfg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .tick  (I2C_TICK)
  );

  assign idx_inc    = idx_q + PTR_W'(1);
  assign retry_left = (retry_q < RTY_W'(MAX_RETRY));

`ifdef SOFT_MUTE_EN
  logic mute_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) mute_q <= 1'b0;
    else       mute_q <= mute;
  end

  assign mute_chg  = mute ^ mute_q;
  assign vol_field = mute_q ? MUTE_CODE : volume_q;
`else
  assign mute_chg  = 1'b0;
  assign vol_field = volume_q;
`endif

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= ST_PWRUP;
    else       state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_PWRUP: if (pwr_cnt_q == PWR_W'(PWRUP_DLY)) state_nxt = ST_ISSUE;
      ST_ISSUE: if (bus.tx_ack) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done) state_nxt = (bus.tx_nack && retry_left) ? ST_ISSUE : ST_NEXT;
      end
      ST_NEXT: begin
        if (vol_pass_q) state_nxt = (idx_q == VOL_R_P) ? ST_IDLE : ST_ISSUE;
        else            state_nxt = (idx_inc == NUM_REGS_P) ? ST_IDLE : ST_ISSUE;
      end
      ST_IDLE:  if (vol_pend_q && VOL_PASS_OK) state_nxt = ST_ISSUE;
      default:  state_nxt = ST_PWRUP;
    endcase
  end

  // Output / datapath next values; everything leaves through a register.
  always_comb begin
    idx_nxt      = idx_q;
    retry_nxt    = retry_q;
    pwr_cnt_nxt  = pwr_cnt_q;
    vol_pass_nxt = vol_pass_q;
    pend_clr     = 1'b0;
    done_nxt     = done_q;
    err_nxt      = err_q;
    case (state_q)
      ST_PWRUP: if (state_nxt == ST_PWRUP) pwr_cnt_nxt = pwr_cnt_q + PWR_W'(1);
      ST_WAIT: begin
        if (bus.tx_done && bus.tx_nack) begin
          if (retry_left) retry_nxt = retry_q + RTY_W'(1);
          else            err_nxt   = 1'b1;
        end
      end
      ST_NEXT: begin
        retry_nxt = '0;
        idx_nxt   = idx_inc;
        if (vol_pass_q && idx_q == VOL_R_P)        vol_pass_nxt = 1'b0;
        if (!vol_pass_q && idx_inc == NUM_REGS_P)  done_nxt     = 1'b1;
      end
      ST_IDLE: begin
        if (vol_pend_q) begin
          pend_clr = 1'b1;
          if (VOL_PASS_OK) begin
            idx_nxt      = VOL_L_P;
            vol_pass_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase

    tx_req_nxt  = (state_nxt == ST_ISSUE);
    busy_nxt    = (state_nxt != ST_IDLE);
    tx_data_nxt = tx_data_q;
    // Word (and volume) is captured on entry to ISSUE and held through the handshake.
    if (state_nxt == ST_ISSUE && state_q != ST_ISSUE) begin
      tx_data_nxt = {DEV_ADDR, cfg_word(idx_nxt[IDX_W-1:0], vol_field)};
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      idx_q      <= '0;
      retry_q    <= '0;
      pwr_cnt_q  <= '0;
      vol_pass_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_nxt;
      retry_q    <= retry_nxt;
      pwr_cnt_q  <= pwr_cnt_nxt;
      vol_pass_q <= vol_pass_nxt;
      tx_req_q   <= tx_req_nxt;
      tx_data_q  <= tx_data_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
    end
  end

  // Saturating volume; simultaneous up/down cancels. A new request beats a same-cycle clear.
  assign up_ok = vol_up && !vol_dn && (volume_q < VOL_MAX);
  assign dn_ok = vol_dn && !vol_up && (volume_q > VOL_MIN);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      volume_q   <= VOL_DEFAULT;
      vol_pend_q <= 1'b0;
    end else begin
      if (up_ok)      volume_q <= volume_q + VOL_W'(1);
      else if (dn_ok) volume_q <= volume_q - VOL_W'(1);
      if (up_ok || dn_ok || mute_chg) vol_pend_q <= 1'b1;
      else if (pend_clr)              vol_pend_q <= 1'b0;
    end
  end

  assign bus.tx_req  = tx_req_q;
  assign bus.tx_data = tx_data_q;
  assign volume      = volume_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;

endmodule
